pipe_skid_reg: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating stall counter. It replaces plain 32-bit stage registers between CPU pipeline stages. A downstream stall therefore back-pressures upstream without a combinational ready path. Flush inserts a bubble on branch or exception.

---
 rtl/pipe_skid_reg_pkg.sv | 12 +
 rtl/pipe_skid_reg_sat_counter.sv | 31 +++
 rtl/pipe_skid_reg.sv | 101 ++++++++++
 tb/tb_pipe_skid_reg.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: stage state encoding and default payload width.
package pipe_skid_reg_pkg;

    localparam int PIPE_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter for performance monitoring; sticks at all-ones until reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a saturating stall counter.
//
// state | meaning
// EMPTY | nothing held; out_valid=0, in_ready=1
// BUSY  | main holds a beat; out_valid=1, in_ready=1
// FULL  | main and skid both hold beats; out_valid=1, in_ready=0
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int WIDTH = PIPE_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept;
    logic             emit;

    // Handshake outputs come from the state register only, so there is no
    // combinational path from out_ready to in_ready or in_valid to out_valid.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q == BUSY) || (state_q == FULL);
    assign out_data  = main_q;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (emit && accept) begin
                        main_d = in_data;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (emit) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid & ~out_ready),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: queue-based reference of the two-entry stage.
module tb_pipe_skid_reg;

    localparam int W  = 32;
    localparam int CW = 4;
    localparam int STALL_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] sb_q[$];
    int           exp_stall = 0;
    bit           exp_zero  = 1'b1;
    int           acc_cnt   = 0;
    int           emit_cnt  = 0;

    pipe_skid_reg #(
        .WIDTH (W),
        .CNT_W (CW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the stage is a FIFO of depth two; transitions are predicted
    // at the falling edge from the inputs that will be seen at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            exp_stall = 0;
            exp_zero  = 1'b1;
        end else begin
            bit ev, er, em, ac;
            ev = (sb_q.size() > 0);
            er = (sb_q.size() < 2);
            chk("out_valid", W'(out_valid), W'(ev));
            chk("in_ready", W'(in_ready), W'(er));
            chk("stall_cnt", W'(stall_cnt), W'(exp_stall));
            if (ev) chk("out_data", out_data, sb_q[0]);
            else if (exp_zero) chk("out_data_zero", out_data, '0);
            em = ev && out_ready;
            ac = er && in_valid;
            if (ev && !out_ready && exp_stall < STALL_MAX) exp_stall++;
            if (em) begin
                void'(sb_q.pop_front());
                emit_cnt++;
            end
            if (flush) begin
                sb_q.delete();
                exp_zero = 1'b1;
            end else if (ac) begin
                sb_q.push_back(in_data);
                exp_zero = 1'b0;
                acc_cnt++;
            end
        end
    end

    task automatic step(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic send(input logic [W-1:0] d, input bit ordy);
        int a0;
        int k;
        a0 = acc_cnt;
        k  = 0;
        step(1'b1, d, ordy, 1'b0);
        forever begin
            @(negedge clk);
            #1;
            if (acc_cnt != a0) break;
            k++;
            if (k > 20) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: beat 0x%0h not accepted within 20 cycles", d);
                break;
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        #12;
        chk("rst_out_data", out_data, '0);
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_stall", W'(stall_cnt), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // streaming at full rate
        for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("stream_emits", W'(emit_cnt), W'(8));

        // back-pressure fills main then skid
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        #2;
        chk("bp_main", out_data, 32'hA);
        chk("bp_skid", u_dut.skid_q, 32'hB);
        chk("bp_in_ready", W'(in_ready), '0);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        send(32'hC, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

        // flush while FULL, with a beat offered in the same cycle
        step(1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        step(1'b1, 32'hD, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        #2;
        chk("flush_out_valid", W'(out_valid), '0);
        chk("flush_out_data", out_data, '0);
        chk("flush_skid", u_dut.skid_q, '0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // flush and in_valid together in EMPTY
        step(1'b1, 32'hE, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        #2;
        chk("flush_empty_valid", W'(out_valid), '0);

        // asynchronous reset while FULL
        step(1'b1, 32'h31, 1'b0, 1'b0);
        step(1'b1, 32'h32, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", W'(out_valid), '0);
        chk("arst_in_ready", W'(in_ready), W'(1));
        chk("arst_out_data", out_data, '0);
        chk("arst_skid", u_dut.skid_q, '0);
        chk("arst_stall", W'(stall_cnt), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, W'(32'h41 + i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // stall counter saturation
        step(1'b1, 32'h55, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
        #2;
        chk("stall_sat", W'(stall_cnt), W'(STALL_MAX));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("drained", W'(sb_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
